// File: rtl/mips_fetch_if.sv
// Instruction-fetch bus between the fetch unit (master) and memory/decode/execute (slave).
interface mips_fetch_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] instr_out;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic [31:0] link_address;
  logic        in_delay_slot;
  logic        active;

  modport master (
    output instr_address,
    input  instr_readdata,
    output instr_out,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_index,
    input  jump_reg,
    input  jump_reg_target,
    output link_address,
    output in_delay_slot,
    output active
  );

  modport slave (
    input  instr_address,
    output instr_readdata,
    input  instr_out,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_index,
    output jump_reg,
    output jump_reg_target,
    input  link_address,
    input  in_delay_slot,
    input  active
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch unit: PC/next-PC, single branch-delay-slot redirects,
// link-address generation and halt on a fetch of HALT_ADDR.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_clk_enable,
  mips_fetch_if.master  io_bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_SLOT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_active;
  logic        r_in_slot;

  logic        [31:0] w_pc_plus4;
  logic signed [31:0] w_br_off;
  logic        [31:0] w_br_target;
  logic        [31:0] w_j_target;
  logic        [31:0] w_target;
  logic               w_redirect;
  logic               w_halt_next;

  always_comb begin
    w_pc_plus4  = r_pc + 32'd4;
    w_br_off    = {{14{io_bus.branch_offset[15]}}, io_bus.branch_offset, 2'b00};
    w_br_target = w_pc_plus4 + w_br_off;
    w_j_target  = {w_pc_plus4[31:28], io_bus.jump_index, 2'b00};
    w_redirect  = io_bus.jump_reg | io_bus.jump | io_bus.branch_taken;
    // Priority: register jump, then absolute jump, then conditional branch.
    if (io_bus.jump_reg) begin
      w_target = io_bus.jump_reg_target;
    end else if (io_bus.jump) begin
      w_target = w_j_target;
    end else begin
      w_target = w_br_target;
    end
    // The next pc is always the current npc, in RUN and SLOT alike.
    w_halt_next = (r_npc == HALT_ADDR);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc      <= RESET_VECTOR;
      r_npc     <= RESET_VECTOR + 32'd4;
      r_state   <= S_RUN;
      r_active  <= 1'b1;
      r_in_slot <= 1'b0;
    end else if (i_clk_enable) begin
      case (r_state)
        S_RUN: begin
          r_pc <= r_npc;
          if (w_halt_next) begin
            r_state   <= S_HALT;
            r_active  <= 1'b0;
            r_in_slot <= 1'b0;
          end else if (w_redirect) begin
            r_npc     <= w_target;
            r_state   <= S_SLOT;
            r_in_slot <= 1'b1;
          end else begin
            r_npc <= r_npc + 32'd4;
          end
        end
        S_SLOT: begin
          // Redirect inputs are ignored for the delay-slot instruction.
          r_pc      <= r_npc;
          r_npc     <= r_npc + 32'd4;
          r_in_slot <= 1'b0;
          if (w_halt_next) begin
            r_state  <= S_HALT;
            r_active <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state   <= S_HALT;
          r_active  <= 1'b0;
          r_in_slot <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.instr_address = r_pc;
  assign io_bus.instr_out     = io_bus.instr_readdata;
  assign io_bus.link_address  = r_pc + 32'd8;
  assign io_bus.in_delay_slot = r_in_slot;
  assign io_bus.active        = r_active;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios plus random redirects against a
// fetch-stream reference model (queue of upcoming fetch addresses).
module tb_mips_fetch_unit;

  logic clk;
  logic rst;
  logic en;

  mips_fetch_if bus ();

  mips_fetch_unit #(
    .RESET_VECTOR (32'hBFC00000),
    .HALT_ADDR    (32'h00000000)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_clk_enable (en),
    .io_bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A1234;
  endfunction

  assign bus.instr_readdata = mem_word(bus.instr_address);

  int n_checks;
  int n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: current fetch address plus the list of addresses still to come.
  logic [31:0] m_pc;
  logic [31:0] m_future[$];
  bit          m_slot;
  bit          m_halt;

  task automatic model_reset();
    m_pc = 32'hBFC00000;
    m_future.delete();
    m_future.push_back(32'hBFC00004);
    m_slot = 0;
    m_halt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    logic [31:0] seq;
    logic [31:0] soff;
    bit          take;
    if (rst) begin
      model_reset();
    end else if (en && !m_halt) begin
      take = 0;
      tgt  = '0;
      if (!m_slot) begin
        seq  = m_pc + 32'd4;
        soff = 32'(signed'(bus.branch_offset));
        if (bus.jump_reg) begin
          take = 1; tgt = bus.jump_reg_target;
        end else if (bus.jump) begin
          take = 1; tgt = {seq[31:28], bus.jump_index, 2'b00};
        end else if (bus.branch_taken) begin
          take = 1; tgt = seq + soff * 32'd4;
        end
      end
      m_pc = m_future.pop_front();
      if (take) m_future.push_back(tgt);
      if (m_future.size() == 0) m_future.push_back(m_pc + 32'd4);
      m_slot = take;
      if (m_pc == 32'h0) begin
        m_halt = 1;
        m_slot = 0;
      end
    end
  endtask

  task automatic check_model();
    chk("addr",   bus.instr_address,         m_pc);
    chk("active", {31'd0, bus.active},        {31'd0, !m_halt});
    chk("slot",   {31'd0, bus.in_delay_slot}, {31'd0, m_slot});
    chk("link",   bus.link_address,          m_pc + 32'd8);
    chk("iout",   bus.instr_out,             mem_word(m_pc));
  endtask

  task automatic clear_redirects();
    bus.branch_taken    = 1'b0;
    bus.branch_offset   = '0;
    bus.jump            = 1'b0;
    bus.jump_index      = '0;
    bus.jump_reg        = 1'b0;
    bus.jump_reg_target = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    en = 1'b1;
    clear_redirects();
    model_reset();

    // Reset and straight-line fetch.
    do_reset();
    chk("rst_addr", bus.instr_address, 32'hBFC00000);
    chk("rst_act",  {31'd0, bus.active}, 32'd1);
    chk("rst_slot", {31'd0, bus.in_delay_slot}, 32'd0);
    tick(); chk("seq1", bus.instr_address, 32'hBFC00004);
    tick(); chk("seq2", bus.instr_address, 32'hBFC00008);
    tick(); chk("seq3", bus.instr_address, 32'hBFC0000C);
    chk("seq_act", {31'd0, bus.active}, 32'd1);

    // Forward branch with delay slot.
    do_reset(); tick(); tick();
    chk("br_link", bus.link_address, 32'hBFC00010);
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0003;
    tick(); clear_redirects();
    chk("br_slot_addr", bus.instr_address, 32'hBFC0000C);
    chk("br_slot_flag", {31'd0, bus.in_delay_slot}, 32'd1);
    tick();
    chk("br_tgt", bus.instr_address, 32'hBFC00018);

    // Backward branch.
    do_reset(); repeat (4) tick();
    bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFF;
    tick(); clear_redirects();
    chk("bbr_slot", bus.instr_address, 32'hBFC00014);
    tick();
    chk("bbr_tgt", bus.instr_address, 32'hBFC00010);

    // Absolute jump.
    do_reset();
    bus.jump = 1'b1; bus.jump_index = 26'h3F00010;
    tick(); clear_redirects();
    chk("j_slot", bus.instr_address, 32'hBFC00004);
    tick();
    chk("j_tgt", bus.instr_address, 32'hBFC00040);

    // Register jump to 0 halts; halted state ignores redirects.
    do_reset(); repeat (11) tick();
    chk("jr_pc", bus.instr_address, 32'hBFC0002C);
    bus.jump_reg = 1'b1; bus.jump_reg_target = 32'h0;
    tick(); clear_redirects();
    chk("jr_slot", bus.instr_address, 32'hBFC00030);
    chk("jr_act_slot", {31'd0, bus.active}, 32'd1);
    tick();
    chk("halt_addr", bus.instr_address, 32'h0);
    chk("halt_act", {31'd0, bus.active}, 32'd0);
    bus.branch_taken = 1'b1; bus.jump = 1'b1; bus.jump_index = 26'h1234;
    bus.jump_reg = 1'b1; bus.jump_reg_target = 32'h400;
    repeat (3) tick();
    clear_redirects();
    chk("halt_hold", bus.instr_address, 32'h0);

    // Stall in the delay slot, then priority of jump_reg over branch.
    do_reset();
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0003;
    tick(); clear_redirects();
    en = 1'b0;
    repeat (3) tick();
    chk("stall_addr", bus.instr_address, 32'hBFC00004);
    chk("stall_slot", {31'd0, bus.in_delay_slot}, 32'd1);
    en = 1'b1;
    tick();
    chk("stall_tgt", bus.instr_address, 32'hBFC00010);
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0005;
    bus.jump_reg = 1'b1; bus.jump_reg_target = 32'h12345670;
    tick(); clear_redirects();
    tick();
    chk("prio_jr", bus.instr_address, 32'h12345670);

    // Reset in the delay slot discards the pending target.
    do_reset();
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0010;
    tick(); clear_redirects();
    do_reset();
    chk("rs_addr", bus.instr_address, 32'hBFC00000);
    chk("rs_slot", {31'd0, bus.in_delay_slot}, 32'd0);
    tick();
    chk("rs_next", bus.instr_address, 32'hBFC00004);

    // Reset while halted.
    bus.jump_reg = 1'b1; bus.jump_reg_target = 32'h0;
    tick(); clear_redirects(); tick();
    chk("rh_halt", {31'd0, bus.active}, 32'd0);
    do_reset();
    chk("rh_addr", bus.instr_address, 32'hBFC00000);
    chk("rh_act",  {31'd0, bus.active}, 32'd1);

    // Address wrap to 0 halts.
    do_reset();
    bus.jump_reg = 1'b1; bus.jump_reg_target = 32'hFFFFFFF8;
    tick(); clear_redirects(); tick(); tick();
    chk("wrap_pc",   bus.instr_address, 32'hFFFFFFFC);
    chk("wrap_link", bus.link_address,  32'h00000004);
    tick();
    chk("wrap_halt", bus.instr_address, 32'h0);
    chk("wrap_act",  {31'd0, bus.active}, 32'd0);

    // Random redirects, stalls and resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst                 = ($urandom_range(0, 99) < 2);
      en                  = ($urandom_range(0, 99) < 85);
      bus.branch_taken    = ($urandom_range(0, 99) < 25);
      bus.branch_offset   = 16'($urandom);
      bus.jump            = ($urandom_range(0, 99) < 10);
      bus.jump_index      = 26'($urandom);
      bus.jump_reg        = ($urandom_range(0, 99) < 10);
      bus.jump_reg_target = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      tick();
    end
    rst = 1'b0;
    clear_redirects();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
